face_detect_sdiv_29s_16ns_13_seq: RTL and testbench



---
 rtl/face_detect_div_pkg.sv | 15 +
 rtl/face_detect_udiv_step.sv | 22 ++
 rtl/face_detect_sdiv_29s_16ns_13_seq.sv | 145 ++++++++++++++
 tb/tb_face_detect_sdiv_29s_16ns_13_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/face_detect_div_pkg.sv
// Shared widths, limits and FSM encoding for the face-detect sequential signed divider.
package face_detect_div_pkg;
  localparam int DIVIDEND_W = 29;
  localparam int DIVISOR_W  = 16;
  localparam int QUOT_W     = 13;
  localparam int REM_W      = DIVISOR_W + 1;
  localparam int MAG_W      = DIVIDEND_W;
  localparam int STEPS      = 28;
  localparam int CNT_W      = 5;

  localparam logic [QUOT_W-1:0] Q_MAX = 13'h0FFF;  // +4095
  localparam logic [QUOT_W-1:0] Q_MIN = 13'h1000;  // -4096

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/face_detect_udiv_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module face_detect_udiv_step
  import face_detect_div_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 q_bit
);
  logic [REM_W:0] trial;
  logic [REM_W:0] dvs_ext;
  logic [REM_W:0] diff;

  always_comb begin
    trial   = {rem_in, bit_in};
    dvs_ext = {{(REM_W + 1 - DIVISOR_W){1'b0}}, divisor};
    diff    = trial - dvs_ext;
    q_bit   = (trial >= dvs_ext);
    rem_out = q_bit ? diff[REM_W-1:0] : trial[REM_W-1:0];
  end
endmodule

// File: rtl/face_detect_sdiv_29s_16ns_13_seq.sv
// Iterative 29s / 16u signed divider: one quotient bit per enabled cycle,
// saturated 13-bit signed quotient, remainder carries the dividend's sign.
module face_detect_sdiv_29s_16ns_13_seq
  import face_detect_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [REM_W-1:0]      remainder,
  output logic                  ovf,
  output logic                  dbz
);
  state_e               state_q, state_d;
  logic [MAG_W-1:0]     mag_q, mag_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [DIVISOR_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d, dz_q, dz_d;
  logic [QUOT_W-1:0]    quo_q, quo_d;
  logic [REM_W-1:0]     rout_q, rout_d;
  logic                 ovf_q, ovf_d, dbz_q, dbz_d;
  logic [MAG_W-1:0]     in_mag;
  logic [MAG_W-1:0]     q_lim;
  logic                 top_q;
  logic [REM_W-1:0]     step_rem;
  logic                 step_bit;

  face_detect_udiv_step u_step (
    .rem_in  (rem_q),
    .bit_in  (mag_q[STEPS-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   state_q <= IDLE;
    else if (ce) state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (divisor == '0) ? FIX : CALC;
      CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    mag_d  = mag_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    dz_d   = dz_q;
    quo_d  = quo_q;
    rout_d = rout_q;
    ovf_d  = ovf_q;
    dbz_d  = dbz_q;
    in_mag = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
    top_q  = 1'b0;
    q_lim  = neg_q ? MAG_W'(4096) : MAG_W'(4095);
    case (state_q)
      IDLE: if (in_valid) begin
        // Only -2^28 sets magnitude bit 28; fold that bit's step in here so
        // the 28 iterations cover bits 27..0.
        top_q = in_mag[STEPS] && (divisor == DIVISOR_W'(1));
        neg_d = dividend[DIVIDEND_W-1];
        dvs_d = divisor;
        dz_d  = (divisor == '0);
        cnt_d = CNT_W'(STEPS);
        mag_d = {top_q, in_mag[STEPS-1:0]};
        rem_d = {{(REM_W-1){1'b0}}, in_mag[STEPS] & ~top_q};
      end
      CALC: begin
        mag_d = {mag_q[MAG_W-1], mag_q[STEPS-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q - 1'b1;
      end
      FIX: begin
        dbz_d = dz_q;
        if (dz_q) begin
          quo_d  = neg_q ? Q_MIN : Q_MAX;
          rout_d = '0;
          ovf_d  = 1'b0;
        end else begin
          ovf_d  = (mag_q > q_lim);
          if (mag_q > q_lim) quo_d = neg_q ? Q_MIN : Q_MAX;
          else               quo_d = neg_q ? (~mag_q[QUOT_W-1:0] + 1'b1) : mag_q[QUOT_W-1:0];
          rout_d = neg_q ? (~rem_q + 1'b1) : rem_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      rout_q <= '0;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else if (ce) begin
      mag_q  <= mag_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      dz_q   <= dz_d;
      quo_q  <= quo_d;
      rout_q <= rout_d;
      ovf_q  <= ovf_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rout_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
endmodule

// File: tb/tb_face_detect_sdiv_29s_16ns_13_seq.sv
// Directed bench: arithmetic reference model plus hand-computed expectations.
module tb_face_detect_sdiv_29s_16ns_13_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [28:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] quotient;
  logic [16:0] remainder;
  logic        ovf, dbz;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [12:0] q;
    logic [16:0] r;
    logic        ovf;
    logic        dbz;
  } res_t;

  res_t exp_q[$];

  face_detect_sdiv_29s_16ns_13_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Reference: plain signed integer division truncating toward zero, then clamp.
  function automatic res_t model(input logic signed [28:0] a, input logic [15:0] d);
    longint sa, sd, qq, rr;
    res_t   res;
    sa = a;
    sd = d;
    res.ovf = 1'b0;
    res.dbz = 1'b0;
    if (sd == 0) begin
      res.dbz = 1'b1;
      res.q   = (sa < 0) ? 13'h1000 : 13'h0FFF;
      res.r   = '0;
    end else begin
      qq = sa / sd;
      rr = sa % sd;
      res.r = rr[16:0];
      if (qq > 4095)       begin res.q = 13'h0FFF; res.ovf = 1'b1; end
      else if (qq < -4096) begin res.q = 13'h1000; res.ovf = 1'b1; end
      else                 res.q = qq[12:0];
    end
    return res;
  endfunction

  // Check DUT against the model on every cycle a result is presented.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("model_quotient",  32'(quotient),  32'(exp_q[0].q));
        chk("model_remainder", 32'(remainder), 32'(exp_q[0].r));
        chk("model_ovf",       32'(ovf),       32'(exp_q[0].ovf));
        chk("model_dbz",       32'(dbz),       32'(exp_q[0].dbz));
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready && ce) void'(exp_q.pop_front());
      end
    end
  end

  task automatic op(input int a, input int d, input int lq, input int lr, input bit lovf,
                    input bit ldbz, input int stall_at, input int stall_len, input int hold);
    int n;
    int lat;
    logic [28:0] av;
    logic [15:0] dv;
    av = a[28:0];
    dv = d[15:0];
    lat = ((d == 0) ? 1 : 29) + stall_len;
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    dividend  = av;
    divisor   = dv;
    @(posedge clk);
    exp_q.push_back(model(av, dv));
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      if (stall_len > 0 && n == stall_at) ce = 1'b0;
      if (stall_len > 0 && n == stall_at + stall_len) ce = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    ce = 1'b1;
    chk("latency_edges", 32'(n), 32'(lat));
    chk("lit_quotient",  32'(quotient),  32'(lq[12:0]));
    chk("lit_remainder", 32'(remainder), 32'(lr[16:0]));
    chk("lit_ovf",       32'(ovf),       32'(lovf));
    chk("lit_dbz",       32'(dbz),       32'(ldbz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready",  32'(in_ready),  32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient",  32'(quotient),  32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_dbz",       32'(dbz),       32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    op(1000, 7, 142, 6, 1'b0, 1'b0, 0, 0, 0);
    op(-1000, 7, -142, -6, 1'b0, 1'b0, 0, 0, 0);
    op(-40960, 10, -4096, 0, 1'b0, 1'b0, 0, 0, 0);
    op(134217728, 3, 4095, 2, 1'b1, 1'b0, 0, 0, 0);
    op(-268435456, 1, -4096, 0, 1'b1, 1'b0, 0, 0, 0);
    op(268435455, 65535, 4095, 4095, 1'b1, 1'b0, 0, 0, 0);
    op(-7, 65535, 0, -7, 1'b0, 1'b0, 0, 0, 0);
    op(500, 0, 4095, 0, 1'b0, 1'b1, 0, 0, 0);
    op(-5, 0, -4096, 0, 1'b0, 1'b1, 0, 0, 0);
    op(1000, 7, 142, 6, 1'b0, 1'b0, 10, 5, 0);
    op(12345, 100, 123, 45, 1'b0, 1'b0, 0, 0, 10);

    // Reset in the middle of CALC discards the operation.
    in_valid = 1'b1;
    dividend = 29'd1000;
    divisor  = 16'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quotient",  32'(quotient),  32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    op(100, 9, 11, 1, 1'b0, 1'b0, 0, 0, 0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
